nvdla_shiftsat_rr_sched: RTL and testbench

Two-requester scheduler sharing one signed shift-right/round/saturate unit (IN_WIDTH→OUT_WIDTH) between independent datapath clients, e.g. two SDP converter lanes. Arbitrates round-robin with valid/ready handshakes and registers the result with a requester tag. Keeps per-requester saturation event counters for status readback. One result per cycle at full throughput.

---
 rtl/nvdla_shiftsat_rr_sched_if.sv | 48 ++++
 rtl/nvdla_shiftsat_rr_sched.sv | 114 +++++++++++
 tb/tb_nvdla_shiftsat_rr_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/nvdla_shiftsat_rr_sched_if.sv
// Handshake and status bundle for the two-requester shift/round/saturate scheduler.
// The scheduler takes the slave view; the requesters, consumer and status reader take the master view.
interface nvdla_shiftsat_rr_sched_if #(
    parameter int IN_WIDTH    = 49,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 32
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [IN_WIDTH-1:0]    req0_data;
    logic [SHIFT_WIDTH-1:0] req0_shift;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [IN_WIDTH-1:0]    req1_data;
    logic [SHIFT_WIDTH-1:0] req1_shift;

    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   out_pd;
    logic                   out_sat;
    logic                   out_id;

    logic                   sat_cnt_clr;
    logic [CNT_WIDTH-1:0]   sat_cnt0;
    logic [CNT_WIDTH-1:0]   sat_cnt1;

    modport slave (
        input  req0_valid, req0_data, req0_shift,
        input  req1_valid, req1_data, req1_shift,
        output req0_ready, req1_ready,
        output out_valid, out_pd, out_sat, out_id,
        input  out_ready,
        input  sat_cnt_clr,
        output sat_cnt0, sat_cnt1
    );

    modport master (
        output req0_valid, req0_data, req0_shift,
        output req1_valid, req1_data, req1_shift,
        input  req0_ready, req1_ready,
        input  out_valid, out_pd, out_sat, out_id,
        output out_ready,
        output sat_cnt_clr,
        input  sat_cnt0, sat_cnt1
    );
endinterface

// File: rtl/nvdla_shiftsat_rr_sched.sv
// Round-robin scheduler sharing one signed shift-right/round/saturate unit between two
// requesters. The result is registered with the requester id, and per-requester saturation
// events are counted at acceptance time.
module nvdla_shiftsat_rr_sched #(
    parameter int IN_WIDTH    = 49,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    nvdla_shiftsat_rr_sched_if.slave   bus
);

    logic                   rr_last;
    logic                   accept;
    logic                   grant0;
    logic                   grant1;
    logic                   xfer0;
    logic                   xfer1;
    logic                   transfer;

    logic [IN_WIDTH-1:0]    sel_data;
    logic [SHIFT_WIDTH-1:0] sel_shift;
    logic [SHIFT_WIDTH-1:0] sh_m1;
    logic signed [IN_WIDTH:0] wide_sh;
    logic [IN_WIDTH-1:0]    floor_val;
    logic [IN_WIDTH-1:0]    sticky_mask;
    logic                   guide;
    logic                   sticky;
    logic                   round_up;
    logic [IN_WIDTH:0]      rounded;
    logic                   sat_hi;
    logic                   sat_lo;
    logic [OUT_WIDTH-1:0]   res_pd;
    logic                   res_sat;

    // The output slot can take a new result when it is empty or being drained this cycle.
    assign accept = ~bus.out_valid | bus.out_ready;

    // Lone valid wins outright; on contention the requester that did not go last wins.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | rr_last);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~rr_last);

    assign bus.req0_ready = grant0 & accept;
    assign bus.req1_ready = grant1 & accept;

    assign xfer0    = bus.req0_valid & bus.req0_ready;
    assign xfer1    = bus.req1_valid & bus.req1_ready;
    assign transfer = xfer0 | xfer1;

    assign sel_data  = grant1 ? bus.req1_data  : bus.req0_data;
    assign sel_shift = grant1 ? bus.req1_shift : bus.req0_shift;

    // Shift with one extra fraction bit so the guide bit falls out at the bottom; negative exact
    // halves stay at the floor while positive halves round up, giving round-half-away for positives.
    always_comb begin
        wide_sh     = $signed({sel_data, 1'b0}) >>> sel_shift;
        floor_val   = wide_sh[IN_WIDTH:1];
        guide       = wide_sh[0];
        sh_m1       = sel_shift - SHIFT_WIDTH'(1);
        sticky_mask = ~({IN_WIDTH{1'b1}} << sh_m1);
        sticky      = (sel_shift != '0) && (|(sel_data & sticky_mask));
        round_up    = guide & (~sel_data[IN_WIDTH-1] | sticky);
        rounded     = {floor_val[IN_WIDTH-1], floor_val} + {{IN_WIDTH{1'b0}}, round_up};
        sat_hi      = ~rounded[IN_WIDTH] & (|rounded[IN_WIDTH-1:OUT_WIDTH-1]);
        sat_lo      = rounded[IN_WIDTH] & ~(&rounded[IN_WIDTH-1:OUT_WIDTH-1]);
        res_pd      = rounded[OUT_WIDTH-1:0];
        res_sat     = 1'b0;
        if (32'(sel_shift) >= IN_WIDTH) begin
            res_pd  = '0;
            res_sat = 1'b0;
        end else if (sat_hi) begin
            res_pd  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            res_sat = 1'b1;
        end else if (sat_lo) begin
            res_pd  = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            res_sat = 1'b1;
        end
    end

    // Output slot and round-robin pointer: load on transfer, empty on drain, hold under backpressure.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            bus.out_valid <= 1'b0;
            bus.out_pd    <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_id    <= 1'b0;
            rr_last       <= 1'b1;
        end else if (transfer) begin
            bus.out_valid <= 1'b1;
            bus.out_pd    <= res_pd;
            bus.out_sat   <= res_sat;
            bus.out_id    <= grant1;
            rr_last       <= grant1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Saturation event counters: clear wins over increment, and each counter sticks at all-ones.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn || bus.sat_cnt_clr) begin
            bus.sat_cnt0 <= '0;
            bus.sat_cnt1 <= '0;
        end else begin
            if (xfer0 && res_sat && !(&bus.sat_cnt0))
                bus.sat_cnt0 <= bus.sat_cnt0 + CNT_WIDTH'(1);
            if (xfer1 && res_sat && !(&bus.sat_cnt1))
                bus.sat_cnt1 <= bus.sat_cnt1 + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_nvdla_shiftsat_rr_sched.sv
// Directed bench for the round-robin shift/round/saturate scheduler with hand-computed results.
// Counters are narrowed to 4 bits so the all-ones hold can be reached quickly.
module tb_nvdla_shiftsat_rr_sched;

    localparam int IN_W  = 49;
    localparam int OUT_W = 32;
    localparam int SH_W  = 6;
    localparam int CNT_W = 4;

    localparam logic [IN_W-1:0] POS_2P40 = 49'h0_0100_0000_0000;
    localparam logic [IN_W-1:0] NEG_2P40 = 49'h1_FF00_0000_0000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;
    int id0_seen;
    int id1_seen;

    logic [IN_W-1:0] rnd_data [4];
    logic [31:0]     rnd_exp  [4];

    nvdla_shiftsat_rr_sched_if #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT_WIDTH(SH_W), .CNT_WIDTH(CNT_W)
    ) bus ();

    nvdla_shiftsat_rr_sched #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT_WIDTH(SH_W), .CNT_WIDTH(CNT_W)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .bus            (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [IN_W-1:0] d0, input logic [SH_W-1:0] s0,
                                 input logic v1, input logic [IN_W-1:0] d1, input logic [SH_W-1:0] s1,
                                 input logic ordy);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req0_shift = s0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req1_shift = s1;
        bus.out_ready  = ordy;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rnd_data[0] = 49'h100;  rnd_exp[0] = 32'h0000_0010;
        rnd_data[1] = 49'h18;   rnd_exp[1] = 32'h0000_0002;
        rnd_data[2] = -49'sd24; rnd_exp[2] = 32'hFFFF_FFFE;
        rnd_data[3] = -49'sd8;  rnd_exp[3] = 32'hFFFF_FFFF;

        bus.sat_cnt_clr = 1'b0;
        applyStimulus(0, '0, '0, 0, '0, '0, 0);
        rstn = 1'b0;
        stepCycle();
        stepCycle();
        rstn = 1'b1;

        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_pd",    64'(bus.out_pd),    64'd0);
        checkOutput("rst_out_sat",   64'(bus.out_sat),   64'd0);
        checkOutput("rst_out_id",    64'(bus.out_id),    64'd0);
        checkOutput("rst_cnt0",      64'(bus.sat_cnt0),  64'd0);
        checkOutput("rst_cnt1",      64'(bus.sat_cnt1),  64'd0);

        // Rounding on req0 only.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, rnd_data[i], 6'd4, 0, '0, '0, 1);
            checkOutput($sformatf("rnd%0d_ready0", i), 64'(bus.req0_ready), 64'd1);
            stepCycle();
            checkOutput($sformatf("rnd%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("rnd%0d_pd", i),    64'(bus.out_pd),    64'(rnd_exp[i]));
            checkOutput($sformatf("rnd%0d_sat", i),   64'(bus.out_sat),   64'd0);
            checkOutput($sformatf("rnd%0d_id", i),    64'(bus.out_id),    64'd0);
        end

        // Saturation on req1 with counter tracking.
        applyStimulus(0, '0, '0, 1, POS_2P40, 6'd0, 1);
        stepCycle();
        checkOutput("satp_pd",   64'(bus.out_pd),   64'h7FFF_FFFF);
        checkOutput("satp_sat",  64'(bus.out_sat),  64'd1);
        checkOutput("satp_id",   64'(bus.out_id),   64'd1);
        checkOutput("satp_cnt1", 64'(bus.sat_cnt1), 64'd1);
        applyStimulus(0, '0, '0, 1, NEG_2P40, 6'd0, 1);
        stepCycle();
        checkOutput("satn_pd",   64'(bus.out_pd),   64'h8000_0000);
        checkOutput("satn_sat",  64'(bus.out_sat),  64'd1);
        checkOutput("satn_cnt1", 64'(bus.sat_cnt1), 64'd2);
        applyStimulus(0, '0, '0, 1, POS_2P40, 6'd49, 1);
        stepCycle();
        checkOutput("sh49_pd",   64'(bus.out_pd),   64'd0);
        checkOutput("sh49_sat",  64'(bus.out_sat),  64'd0);
        checkOutput("sh49_cnt1", 64'(bus.sat_cnt1), 64'd2);
        checkOutput("sh49_cnt0", 64'(bus.sat_cnt0), 64'd0);

        // Round-robin with both requesters valid; last grant was req1 so req0 goes first.
        id0_seen = 0;
        id1_seen = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 49'(32'h100 + i), 6'd0, 1, 49'(32'h200 + i), 6'd0, 1);
            checkOutput($sformatf("rr%0d_ready0", i), 64'(bus.req0_ready), 64'((i % 2) == 0));
            checkOutput($sformatf("rr%0d_ready1", i), 64'(bus.req1_ready), 64'((i % 2) == 1));
            stepCycle();
            checkOutput($sformatf("rr%0d_id", i), 64'(bus.out_id), 64'(i % 2));
            checkOutput($sformatf("rr%0d_pd", i), 64'(bus.out_pd),
                        ((i % 2) == 0) ? 64'(32'h100 + i) : 64'(32'h200 + i));
            if (bus.out_id) id1_seen++;
            else            id0_seen++;
        end
        checkOutput("rr_count0", 64'(id0_seen), 64'd4);
        checkOutput("rr_count1", 64'(id1_seen), 64'd4);

        // Backpressure: held result must stay put and both readys drop.
        applyStimulus(1, 49'h300, 6'd0, 1, 49'h400, 6'd0, 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp%0d_ready0", k), 64'(bus.req0_ready), 64'd0);
            checkOutput($sformatf("bp%0d_ready1", k), 64'(bus.req1_ready), 64'd0);
            checkOutput($sformatf("bp%0d_valid", k),  64'(bus.out_valid),  64'd1);
            checkOutput($sformatf("bp%0d_pd", k),     64'(bus.out_pd),     64'h207);
            stepCycle();
        end
        applyStimulus(1, 49'h300, 6'd0, 1, 49'h400, 6'd0, 1);
        checkOutput("bp_rel_ready0", 64'(bus.req0_ready), 64'd1);
        stepCycle();
        checkOutput("bp_rel_pd0", 64'(bus.out_pd), 64'h300);
        checkOutput("bp_rel_id0", 64'(bus.out_id), 64'd0);
        checkOutput("bp_rel_ready1", 64'(bus.req1_ready), 64'd1);
        stepCycle();
        checkOutput("bp_rel_pd1", 64'(bus.out_pd), 64'h400);
        checkOutput("bp_rel_id1", 64'(bus.out_id), 64'd1);
        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        stepCycle();
        checkOutput("drain_valid", 64'(bus.out_valid), 64'd0);

        // Counter hold at all-ones on req0.
        applyStimulus(1, POS_2P40, 6'd0, 0, '0, '0, 1);
        for (int i = 0; i < 17; i++) begin
            stepCycle();
            checkOutput($sformatf("hold%0d_cnt0", i), 64'(bus.sat_cnt0), (i + 1 < 15) ? 64'(i + 1) : 64'd15);
        end
        checkOutput("hold_sat", 64'(bus.out_sat), 64'd1);

        // Clear coincident with a saturating transfer.
        bus.sat_cnt_clr = 1'b1;
        stepCycle();
        bus.sat_cnt_clr = 1'b0;
        checkOutput("clr_cnt0", 64'(bus.sat_cnt0), 64'd0);
        checkOutput("clr_cnt1", 64'(bus.sat_cnt1), 64'd0);
        stepCycle();
        checkOutput("post_clr_cnt0", 64'(bus.sat_cnt0), 64'd1);

        // Reset while a result is held under backpressure; last grant was req0.
        applyStimulus(1, POS_2P40, 6'd0, 1, 49'h5, 6'd0, 0);
        checkOutput("prerst_valid", 64'(bus.out_valid), 64'd1);
        rstn = 1'b0;
        stepCycle();
        rstn = 1'b1;
        checkOutput("midrst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midrst_pd",    64'(bus.out_pd),    64'd0);
        checkOutput("midrst_cnt0",  64'(bus.sat_cnt0),  64'd0);
        checkOutput("midrst_cnt1",  64'(bus.sat_cnt1),  64'd0);
        applyStimulus(1, POS_2P40, 6'd0, 1, 49'h5, 6'd0, 1);
        checkOutput("postrst_ready0", 64'(bus.req0_ready), 64'd1);
        checkOutput("postrst_ready1", 64'(bus.req1_ready), 64'd0);
        stepCycle();
        checkOutput("postrst_id",    64'(bus.out_id),    64'd0);
        checkOutput("postrst_pd",    64'(bus.out_pd),    64'h7FFF_FFFF);
        checkOutput("postrst_cnt0",  64'(bus.sat_cnt0),  64'd1);

        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
